// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
// Serial bit-pattern transmitter that drives sequence detectors. A WIDTH-bit
// pattern is sent MSB-first on x, once per repetition, `repeats` times. An
// optional idle gap of `gap` cycles separates consecutive repetitions.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a job; sampled only in IDLE and ignored while abort=1
//   abort      drop an active job at the next edge (no done pulse)
//   pattern    bits to send, MSB first; latched when start is accepted
//   repeats    repetition count; latched when start is accepted (0 = done only)
//   gap        idle cycles between repetitions; latched when start is accepted
//   x          serial data line (0 whenever valid=0)
//   valid      x carries a pattern bit this cycle
//   pat_end    last bit of a repetition (only together with valid)
//   busy       job in progress, from the first bit to the last bit of the job
//   done       one-cycle pulse after a job completes normally
//   fsm_state  current FSM state, for observation only
//
// Handshake: there is no ready signal. A start is taken on any edge where the
// FSM is in IDLE and abort is low. Outputs follow one cycle after that edge.
// Because done is raised while the FSM is already back in IDLE, a new start
// may be presented in the same cycle that done is high.
module seq_pattern_gen #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             valid,
  output logic             pat_end,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] PENULT_BIT = BIT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] ONE_REP = CNT_W'(1);
  localparam logic [GAP_W-1:0] ONE_GAP = GAP_W'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] pat_q;     // latched pattern, reloaded every repetition
  logic [WIDTH-1:0] shreg;     // bits still to send in this repetition
  logic [CNT_W-1:0] rep_left;  // repetitions remaining, including the current one
  logic [GAP_W-1:0] gap_q;     // latched gap length
  logic [GAP_W-1:0] gap_left;  // gap cycles remaining, including the current one
  logic [BIT_W-1:0] bit_idx;   // index of the bit currently on x

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pat_q    <= '0;
      shreg    <= '0;
      rep_left <= '0;
      gap_q    <= '0;
      gap_left <= '0;
      bit_idx  <= '0;
      x        <= 1'b0;
      valid    <= 1'b0;
      pat_end  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      pat_end <= 1'b0;
      case (state)
        S_IDLE: begin
          x     <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          if (start && !abort) begin
            if (repeats != '0) begin
              pat_q    <= pattern;
              rep_left <= repeats;
              gap_q    <= gap;
              shreg    <= pattern << 1;
              x        <= pattern[WIDTH-1];
              valid    <= 1'b1;
              busy     <= 1'b1;
              bit_idx  <= '0;
              state    <= S_SEND;
            end else begin
              // Empty job: finish immediately without touching the line.
              done <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (abort) begin
            state    <= S_IDLE;
            shreg    <= '0;
            rep_left <= '0;
            gap_left <= '0;
            bit_idx  <= '0;
            x        <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
          end else if (bit_idx == LAST_BIT) begin
            // Guard on <= 1 so the counter can never wrap below zero.
            if (rep_left <= ONE_REP) begin
              state    <= S_IDLE;
              rep_left <= '0;
              shreg    <= '0;
              bit_idx  <= '0;
              x        <= 1'b0;
              valid    <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              rep_left <= rep_left - ONE_REP;
              if (gap_q == '0) begin
                // Back-to-back repetition: MSB follows the last bit directly.
                shreg   <= pat_q << 1;
                x       <= pat_q[WIDTH-1];
                valid   <= 1'b1;
                busy    <= 1'b1;
                bit_idx <= '0;
              end else begin
                state    <= S_GAP;
                gap_left <= gap_q;
                x        <= 1'b0;
                valid    <= 1'b0;
                busy     <= 1'b1;
              end
            end
          end else begin
            x       <= shreg[WIDTH-1];
            shreg   <= shreg << 1;
            bit_idx <= bit_idx + 1'b1;
            valid   <= 1'b1;
            busy    <= 1'b1;
            pat_end <= (bit_idx == PENULT_BIT);
          end
        end

        S_GAP: begin
          if (abort) begin
            state    <= S_IDLE;
            shreg    <= '0;
            rep_left <= '0;
            gap_left <= '0;
            bit_idx  <= '0;
            x        <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
          end else if (gap_left <= ONE_GAP) begin
            state    <= S_SEND;
            gap_left <= '0;
            shreg    <= pat_q << 1;
            x        <= pat_q[WIDTH-1];
            valid    <= 1'b1;
            busy     <= 1'b1;
            bit_idx  <= '0;
          end else begin
            gap_left <= gap_left - ONE_GAP;
            x        <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          x     <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
